// File: rtl/ssg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with a per-digit register file.
// Each entry holds a hex digit plus dp, blank and blink. The scanner adds leading-zero blanking and a dark slot between digits.
module ssg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SEL_W        = 3,
    parameter int PRESCALE     = 4,
    parameter int BLINK_FRAMES = 4
) (
    input  logic              i_w_clk,
    input  logic              i_w_reset,
    input  logic              i_w_we,
    input  logic [SEL_W-1:0]  i_w_sel,
    input  logic [3:0]        i_w_dig,
    input  logic              i_w_dp,
    input  logic              i_w_blank,
    input  logic              i_w_blink,
    input  logic              i_w_lzb,
    output logic [7:0]        o_w_out,
    output logic [DIGITS-1:0] o_w_sel,
    output logic              o_w_frame
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIGITS-1:0][3:0] dig_q;
    logic [DIGITS-1:0]      dp_q, blank_q, blink_q;

    // Only addresses 0..DIGITS-1 have a matching entry, so out-of-range writes fall through.
    for (genvar j = 0; j < DIGITS; j++) begin : g_entry
        always_ff @(posedge i_w_clk or negedge i_w_reset) begin
            if (!i_w_reset) begin
                dig_q[j]   <= 4'h0;
                dp_q[j]    <= 1'b0;
                blank_q[j] <= 1'b1;
                blink_q[j] <= 1'b0;
            end else if (i_w_we && i_w_sel == SEL_W'(j)) begin
                dig_q[j]   <= i_w_dig;
                dp_q[j]    <= i_w_dp;
                blank_q[j] <= i_w_blank;
                blink_q[j] <= i_w_blink;
            end
        end
    end

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [FRM_W-1:0] frm;
    logic             phase;
    logic             slot_end, frame_end;

    assign slot_end  = (cnt == CNT_W'(PRESCALE - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            cnt   <= '0;
            idx   <= '0;
            frm   <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= frame_end ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (frm == FRM_W'(BLINK_FRAMES - 1)) begin
                    frm   <= '0;
                    phase <= ~phase;
                end else begin
                    frm <= frm + 1'b1;
                end
            end
        end
    end

    // Walk down from the top entry; an entry is suppressed while everything from it upward is a bare zero.
    logic [DIGITS-1:0] sup;
    logic              upper_zero;
    always_comb begin
        sup        = '0;
        upper_zero = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            upper_zero = upper_zero && (dig_q[j] == 4'h0) && !dp_q[j];
            sup[j]     = i_w_lzb && upper_zero && (j != 0);
        end
    end

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
        endcase
    endfunction

    logic       dark;
    logic [7:0] seg;
    logic [7:0] out_d;
    always_comb begin
        dark  = blank_q[idx] || (blink_q[idx] && phase) || sup[idx];
        seg   = hex_seg(dig_q[idx]);
        out_d = dark ? 8'hFF : {~dp_q[idx], seg[6:0]};
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            o_w_out   <= 8'hFF;
            o_w_sel   <= '1;
            o_w_frame <= 1'b0;
        end else begin
            o_w_frame <= frame_end;
            if (slot_end) begin
                o_w_out <= 8'hFF;
                o_w_sel <= '1;
            end else begin
                o_w_out <= out_d;
                o_w_sel <= ~(DIGITS'(1) << idx);
            end
        end
    end
endmodule

// File: tb/tb_ssg_scan_ctrl.sv
// Directed bench for ssg_scan_ctrl at DIGITS=4, PRESCALE=4, BLINK_FRAMES=2.
// Edge n counts clock edges since reset release; outputs are sampled 1 ns after each edge.
module tb_ssg_scan_ctrl;
    logic       clk, rst_n, we, dp, blank, blink, lzb;
    logic [2:0] sel;
    logic [3:0] dig;
    logic [7:0] seg_out;
    logic [3:0] an;
    logic       frame;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    ssg_scan_ctrl #(.DIGITS(4), .SEL_W(3), .PRESCALE(4), .BLINK_FRAMES(2)) dut (
        .i_w_clk(clk), .i_w_reset(rst_n), .i_w_we(we), .i_w_sel(sel), .i_w_dig(dig),
        .i_w_dp(dp), .i_w_blank(blank), .i_w_blink(blink), .i_w_lzb(lzb),
        .o_w_out(seg_out), .o_w_sel(an), .o_w_frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic goto_edge(input int k);
        while (ecount < k) step();
    endtask

    task automatic wr(input logic [2:0] s, input logic [3:0] d, input logic p,
                      input logic b, input logic bl);
        we = 1'b1; sel = s; dig = d; dp = p; blank = b; blink = bl;
        step();
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ecount = 0;
    endtask

    // Full frame from edge 'first': three lit cycles then a dark cycle per digit, pulse in the last cycle.
    task automatic check_frame(input string tag, input int first,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] dv[4];
        logic [3:0] one;
        dv = '{d0, d1, d2, d3};
        one = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            goto_edge(first + i);
            if (i % 4 == 3) begin
                chk($sformatf("%s e%0d out", tag, ecount), seg_out, 8'hFF);
                chk($sformatf("%s e%0d sel", tag, ecount), {4'h0, an}, 8'h0F);
            end else begin
                chk($sformatf("%s e%0d out", tag, ecount), seg_out, dv[i / 4]);
                chk($sformatf("%s e%0d sel", tag, ecount), {4'h0, an}, {4'h0, ~(one << (i / 4))});
            end
            chk($sformatf("%s e%0d frame", tag, ecount), {7'h0, frame}, {7'h0, i == 15});
        end
    endtask

    initial begin
        we = 0; sel = 0; dig = 0; dp = 0; blank = 0; blink = 0; lzb = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset out", seg_out, 8'hFF);
        chk("reset sel", {4'h0, an}, 8'h0F);
        chk("reset frame", {7'h0, frame}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        ecount = 0;

        // Scan with digits 1,2,3,4
        wr(3'd0, 4'h1, 0, 0, 0);
        chk("first edge sel", {4'h0, an}, 8'h0E);
        chk("first edge out blank", seg_out, 8'hFF);
        chk("first edge frame", {7'h0, frame}, 8'h00);
        wr(3'd1, 4'h2, 0, 0, 0);
        chk("digit0 after write", seg_out, 8'hF9);
        wr(3'd2, 4'h3, 0, 0, 0);
        wr(3'd3, 4'h4, 0, 0, 0);
        chk("first dead out", seg_out, 8'hFF);
        chk("first dead sel", {4'h0, an}, 8'h0F);
        check_frame("scan", 17, 8'hF9, 8'hA4, 8'hB0, 8'h99);

        // Decimal point on digit 2, then an out-of-range write
        goto_edge(32);
        wr(3'd2, 4'h0, 1, 0, 0);
        wr(3'd5, 4'h8, 0, 0, 0);
        check_frame("dp_oor", 49, 8'hF9, 8'hA4, 8'h40, 8'h99);

        // Leading-zero blanking: entries 3..0 = 0,0,7,0
        goto_edge(64);
        lzb = 1'b1;
        wr(3'd3, 4'h0, 0, 0, 0);
        wr(3'd2, 4'h0, 0, 0, 0);
        wr(3'd1, 4'h7, 0, 0, 0);
        wr(3'd0, 4'h0, 0, 0, 0);
        check_frame("lzb", 81, 8'hC0, 8'hF8, 8'hFF, 8'hFF);
        lzb = 1'b0;
        check_frame("nolzb", 97, 8'hC0, 8'hF8, 8'hC0, 8'hC0);

        // Write to the digit currently lit
        goto_edge(113);
        chk("live pre", seg_out, 8'hC0);
        wr(3'd0, 4'hF, 0, 0, 0);
        chk("live write edge", seg_out, 8'hC0);
        step();
        chk("live next edge", seg_out, 8'h8E);

        // Asynchronous reset while digit 2 is lit
        goto_edge(121);
        chk("mid digit2 sel", {4'h0, an}, 8'h0B);
        chk("mid digit2 out", seg_out, 8'hC0);
        #3 rst_n = 1'b0;
        #1;
        chk("async out", seg_out, 8'hFF);
        chk("async sel", {4'h0, an}, 8'h0F);
        chk("async frame", {7'h0, frame}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        ecount = 0;
        check_frame("post_rst", 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Blink: digit 1 = 5, two frames on, two frames off
        do_reset();
        wr(3'd1, 4'h5, 0, 0, 1);
        for (int n = 0; n < 6; n++) begin
            goto_edge(16 * n + 6);
            chk($sformatf("blink frame%0d", n), seg_out, (n < 2 || n >= 4) ? 8'h92 : 8'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ssg_scan_ctrl.md
# ssg_scan_ctrl

Parametrised multiplexed seven-segment display controller, the successor of the fixed-size sequential seven-segment block. It holds a per-digit register file written over a simple write port and scans a common-anode display of `DIGITS` positions. It adds per-digit decimal point, blank and blink attributes, leading-zero blanking and anti-ghosting dead time. It sits between the datapath/debug logic and the board display pins.

## Interface
- `DIGITS`, 8: number of display positions, 2..2^`SEL_W`.
- `SEL_W`, 3: write-address width.
- `PRESCALE`, 4: clock cycles per digit slot, must be ≥2. Board builds override it, for example 50000.
- `BLINK_FRAMES`, 4: number of frames per blink half-period, must be ≥1.

Ports:
- `i_w_clk` in 1: clock, rising edge.
- `i_w_reset` in 1: reset, asynchronous, active-low.
- `i_w_we` in 1: write enable.
- `i_w_sel` in `SEL_W`: write address; 0 is the least significant digit.
- `i_w_dig` in 4: hex value to write.
- `i_w_dp` in 1: decimal point to write.
- `i_w_blank` in 1: blank attribute to write.
- `i_w_blink` in 1: blink attribute to write.
- `i_w_lzb` in 1: leading-zero blanking enable; level, read every cycle.
- `o_w_out` out 8: segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- `o_w_sel` out `DIGITS`: anodes, one-hot active-low, registered.
- `o_w_frame` out 1: one-cycle pulse at each frame wrap, registered.

## Operation
- **Register file.** There are `DIGITS` entries, each {blink, blank, dp, dig[3:0]}. Reset value of every entry: dig=0, dp=0, blank=1, blink=0.
- **Writes.** A write occurs at a rising edge with `i_w_we`=1 and `i_w_sel` < `DIGITS`. If `i_w_sel` ≥ `DIGITS`, the write is silently ignored.
- **Scan counters.**
  - `cnt` runs 0..`PRESCALE`-1.
  - `idx` runs 0..`DIGITS`-1 and advances when `cnt`=`PRESCALE`-1, wrapping from `DIGITS`-1 to 0.
  - Both counters reset to 0.
- **Blink phase.**
  - A frame counter increments at each `idx` wrap.
  - The blink phase bit toggles every `BLINK_FRAMES` frames.
  - The phase bit and the frame counter reset to 0.
- **Leading-zero blanking.** With `i_w_lzb`=1, an entry j > 0 is suppressed when both hold:
  - it has dig=0 and dp=0;
  - every entry above j (up to `DIGITS`-1) also has dig=0 and dp=0.
  - Entry 0 is never suppressed by this rule.
- **Visibility.** The entry at `idx` is dark when any of the following holds:
  - its blank attribute is 1;
  - its blink attribute is 1 and the blink phase is 1;
  - it is suppressed by leading-zero blanking.
- **Output register.** At every edge it loads a value computed from the pre-edge state:
  - if `cnt`=`PRESCALE`-1 (dead time): `o_w_sel`=all ones, `o_w_out`=8'hFF;
  - otherwise: `o_w_sel`=~(1<<`idx`); `o_w_out`=8'hFF if the entry is dark, else the hex decode of dig with bit 7 = ~dp.
- **Hex decode** of {g..a}, active-low, dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- **Frame pulse.** `o_w_frame`=1 for the cycle after an edge at which `cnt`=`PRESCALE`-1 and `idx`=`DIGITS`-1. It coincides with the dead cycle.

## Timing
- **Reset values.** `o_w_out`=8'hFF, `o_w_sel`=all ones, `o_w_frame`=0.
- **Reset assertion.** Asserting `i_w_reset` mid-scan drives these values immediately, with no clock needed, and clears the register file and all counters.
- **After reset release.** The first edge shows digit 0: `o_w_sel`=~1. It also shows entry 0 blanked, because blank=1 after reset.
- **Slot and frame length.** Each slot is `PRESCALE` cycles: `PRESCALE`-1 lit cycles followed by 1 dark cycle. A frame is `DIGITS`×`PRESCALE` cycles.
- **Write latency.** A write at edge k to the digit being displayed appears on `o_w_out` from edge k+1, unless edge k+1 is dead time.
- **Attribute and level changes.** Changes to blink, blank or `i_w_lzb` take effect at the next output-register load.
- **Write during dead time or frame wrap.** No interaction; the write is accepted normally.
- **Repeated writes.** Multiple writes to the same address in consecutive cycles are allowed; the last one wins.

## Test plan
All scenarios use `DIGITS`=4, `PRESCALE`=4, `BLINK_FRAMES`=2.
- **Reset and scan.**
  - Stimulus: after reset release, write entries 0..3 = 1, 2, 3, 4 with blank=0.
  - Response: `o_w_sel` cycles E, E, E, F, D, D, D, F, B, ..., 7. `o_w_out` = F9/A4/B0/99 in the matching lit cycles and FF in dead cycles. `o_w_frame` is high exactly once every 16 cycles, in the dead cycle after digit 3.
- **Decimal point and out-of-range address.**
  - Stimulus: write sel=2, dig=0, dp=1; then write sel=5, dig=8.
  - Response: digit 2 shows 8'h40. No entry changes, and all digits remain as before.
- **Leading-zero blanking.**
  - Stimulus: entries 3..0 = 0, 0, 7, 0 with `i_w_lzb`=1.
  - Response: digits 3 and 2 show FF; digit 1 shows F8; digit 0 shows C0.
  - Follow-on: with `i_w_lzb`=0, digits 3 and 2 show C0.
- **Blink.**
  - Stimulus: entry 1 = 5 with blink=1.
  - Response: digit 1 shows 92 for frames 0–1, FF for frames 2–3, and 92 again for frames 4–5.
- **Asynchronous reset mid-frame.**
  - Stimulus: pull `i_w_reset` low between edges while digit 2 is lit.
  - Response: outputs go to FF / F / 0 before the next edge. After release, scanning restarts at digit 0 with all entries blank.
- **Write to the live digit.**
  - Stimulus: while digit 0 is lit, write sel=0, dig=F.
  - Response: `o_w_out`=8E from the next edge, with no gap.
